// File: rtl/hazard_stall_controller_pkg.sv
// Shared types and constants for the hazard/stall controller.
// Holds the MULT/DIV sequencer state encoding and op encodings.
package hazard_stall_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  // BUSY counter preload: the DONE cycle and the start cycle
  // are not spent in BUSY, hence the -2.
  function automatic logic [5:0] busy_load(input int cycles);
    return 6'(cycles - 2);
  endfunction

endpackage

// File: rtl/muldiv_sequencer.sv
// Sequencer tracking HI/LO occupancy of the multi-cycle MULT/DIV unit.
// Ports: i_start/i_op from EX; o_busy (state!=IDLE), o_done (HI/LO strobe).
module muldiv_sequencer
  import hazard_stall_controller_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_op,
  output logic o_busy,
  output logic o_done
);

  localparam logic [5:0] MULT_LOAD = busy_load(MULT_CYCLES);
  localparam logic [5:0] DIV_LOAD  = busy_load(DIV_CYCLES);

  md_state_e  r_state;
  md_state_e  w_state_nxt;
  logic [5:0] r_cnt;
  logic [5:0] w_cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 6'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A start while BUSY/DONE is ignored: those arms never look at it.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_done      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_cnt_nxt   = (i_op == OP_DIV) ? DIV_LOAD : MULT_LOAD;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (r_cnt == 6'd0) w_state_nxt = ST_DONE;
        else               w_cnt_nxt   = r_cnt - 6'd1;
      end
      ST_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_busy = (r_state != ST_IDLE);

endmodule

// File: rtl/hazard_stall_controller.sv
// Load-use / HI/LO stall and branch-flush control for the 5-stage core.
// Ports: hazard inputs from IF/ID and ID/EX; PC/IF-ID enables, flushes, StallCount.
module hazard_stall_controller
  import hazard_stall_controller_pkg::*;
#(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MemReadIDEX,
  input  logic [4:0]       rtIDEX,
  input  logic [4:0]       rsIFID,
  input  logic [4:0]       rtIFID,
  input  logic             UsesRtIFID,
  input  logic             MulDivStartIDEX,
  input  logic             MulDivOpIDEX,
  input  logic             HiLoUseIFID,
  input  logic             BranchTakenID,
  input  logic             StallCountClr,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IDEXFlush,
  output logic             IFIDFlush,
  output logic             MulDivBusy,
  output logic             MulDivDone,
  output logic [CNT_W-1:0] StallCount
);

  logic             w_busy;
  logic             w_load_use;
  logic             w_hilo_haz;
  logic             w_stall;
  logic [CNT_W-1:0] r_stall_cnt;

  muldiv_sequencer #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_seq (
    .clk    (clk),
    .rst    (rst),
    .i_start(MulDivStartIDEX),
    .i_op   (MulDivOpIDEX),
    .o_busy (w_busy),
    .o_done (MulDivDone)
  );

  assign MulDivBusy = w_busy;

  // r0 is never a real dependency.
  assign w_load_use = MemReadIDEX
                    & (rtIDEX != REG_ZERO)
                    & ((rtIDEX == rsIFID)
                     | (UsesRtIFID & (rtIDEX == rtIFID)));

  // Readers wait through DONE so HI/LO is written first.
  assign w_hilo_haz = HiLoUseIFID & (MulDivStartIDEX | w_busy);

  assign w_stall = w_load_use | w_hilo_haz;

  // Stall wins over redirect: the branch stays in ID and
  // flushes on its first non-stalled cycle.
  assign PCWrite   = ~w_stall;
  assign IFIDWrite = ~w_stall;
  assign IDEXFlush =  w_stall;
  assign IFIDFlush = ~w_stall & BranchTakenID;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (StallCountClr) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign StallCount = r_stall_cnt;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller.
// Vector table, directed multi-cycle sequences and random traffic vs a model.
module tb_hazard_stall_controller;

  localparam int MC = 4;
  localparam int DC = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MemReadIDEX = 0;
  logic [4:0]  rtIDEX = 0;
  logic [4:0]  rsIFID = 0;
  logic [4:0]  rtIFID = 0;
  logic        UsesRtIFID = 0;
  logic        MulDivStartIDEX = 0;
  logic        MulDivOpIDEX = 0;
  logic        HiLoUseIFID = 0;
  logic        BranchTakenID = 0;
  logic        StallCountClr = 0;
  logic        PCWrite, IFIDWrite, IDEXFlush, IFIDFlush;
  logic        MulDivBusy, MulDivDone;
  logic [15:0] StallCount;
  logic        s_PCWrite, s_IFIDWrite, s_IDEXFlush, s_IFIDFlush;
  logic        s_MulDivBusy, s_MulDivDone;
  logic [3:0]  s_StallCount;

  always #5 clk = ~clk;

  hazard_stall_controller #(
    .MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(16)
  ) u_dut (
    .clk(clk), .rst(rst),
    .MemReadIDEX(MemReadIDEX), .rtIDEX(rtIDEX),
    .rsIFID(rsIFID), .rtIFID(rtIFID), .UsesRtIFID(UsesRtIFID),
    .MulDivStartIDEX(MulDivStartIDEX), .MulDivOpIDEX(MulDivOpIDEX),
    .HiLoUseIFID(HiLoUseIFID), .BranchTakenID(BranchTakenID),
    .StallCountClr(StallCountClr),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
    .IDEXFlush(IDEXFlush), .IFIDFlush(IFIDFlush),
    .MulDivBusy(MulDivBusy), .MulDivDone(MulDivDone),
    .StallCount(StallCount)
  );

  // Narrow counter copy so saturation is reachable quickly.
  hazard_stall_controller #(
    .MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(4)
  ) u_sat (
    .clk(clk), .rst(rst),
    .MemReadIDEX(MemReadIDEX), .rtIDEX(rtIDEX),
    .rsIFID(rsIFID), .rtIFID(rtIFID), .UsesRtIFID(UsesRtIFID),
    .MulDivStartIDEX(MulDivStartIDEX), .MulDivOpIDEX(MulDivOpIDEX),
    .HiLoUseIFID(HiLoUseIFID), .BranchTakenID(BranchTakenID),
    .StallCountClr(StallCountClr),
    .PCWrite(s_PCWrite), .IFIDWrite(s_IFIDWrite),
    .IDEXFlush(s_IDEXFlush), .IFIDFlush(s_IFIDFlush),
    .MulDivBusy(s_MulDivBusy), .MulDivDone(s_MulDivDone),
    .StallCount(s_StallCount)
  );

  int n_pass = 0;
  int n_tot  = 0;

  // Model: cycles of HI/LO occupancy left (busy while >0, done at 1).
  int m_left = 0;
  int m_cnt  = 0;
  int m_sat  = 0;

  logic l_pc, l_idexfl, l_ifidfl, l_busy, l_done;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else
      n_pass++;
  endtask

  // Called at a negedge with inputs already driven; returns at next negedge.
  task automatic cycle();
    bit lu, hz, stl, busy, done;
    logic [5:0] exp_v;
    int nl, nc, ns;
    #1;
    busy = (m_left > 0);
    done = (m_left == 1);
    lu = MemReadIDEX && (rtIDEX != 0) &&
         ((rtIDEX == rsIFID) || (UsesRtIFID && (rtIDEX == rtIFID)));
    hz = HiLoUseIFID && (MulDivStartIDEX || busy);
    stl = lu || hz;
    exp_v = {!stl, !stl, stl, !stl && BranchTakenID, busy, done};
    chk("ctrl", {26'd0, PCWrite, IFIDWrite, IDEXFlush, IFIDFlush,
                 MulDivBusy, MulDivDone}, {26'd0, exp_v});
    chk("stall_count", {16'd0, StallCount}, m_cnt);
    chk("sat_count", {28'd0, s_StallCount}, m_sat);
    l_pc = PCWrite; l_idexfl = IDEXFlush; l_ifidfl = IFIDFlush;
    l_busy = MulDivBusy; l_done = MulDivDone;
    if (m_left > 0)           nl = m_left - 1;
    else if (MulDivStartIDEX) nl = MulDivOpIDEX ? DC : MC;
    else                      nl = 0;
    if (StallCountClr) begin
      nc = 0; ns = 0;
    end else begin
      nc = (stl && m_cnt < 65535) ? m_cnt + 1 : m_cnt;
      ns = (stl && m_sat < 15) ? m_sat + 1 : m_sat;
    end
    @(posedge clk);
    #1;
    m_left = nl; m_cnt = nc; m_sat = ns;
    @(negedge clk);
  endtask

  task automatic idle_in();
    MemReadIDEX = 0; rtIDEX = 0; rsIFID = 0; rtIFID = 0;
    UsesRtIFID = 0; MulDivStartIDEX = 0; MulDivOpIDEX = 0;
    HiLoUseIFID = 0; BranchTakenID = 0; StallCountClr = 0;
  endtask

  typedef struct {
    logic       mr;
    logic [4:0] rte, rs, rt;
    logic       ur, br;
    logic       e_pc, e_idexfl, e_ifidfl;
  } vec_t;

  vec_t vt[10];

  initial begin
    vt[0] = '{1, 5'd8,  5'd8, 5'd0,  0, 0, 0, 1, 0};
    vt[1] = '{1, 5'd0,  5'd0, 5'd0,  1, 0, 1, 0, 0};
    vt[2] = '{1, 5'd9,  5'd3, 5'd9,  0, 0, 1, 0, 0};
    vt[3] = '{1, 5'd9,  5'd3, 5'd9,  1, 0, 0, 1, 0};
    vt[4] = '{0, 5'd8,  5'd8, 5'd0,  0, 0, 1, 0, 0};
    vt[5] = '{0, 5'd0,  5'd1, 5'd2,  0, 1, 1, 0, 1};
    vt[6] = '{1, 5'd5,  5'd5, 5'd0,  0, 1, 0, 1, 0};
    vt[7] = '{0, 5'd5,  5'd5, 5'd0,  0, 1, 1, 0, 1};
    vt[8] = '{1, 5'd31, 5'd1, 5'd31, 1, 0, 0, 1, 0};
    vt[9] = '{1, 5'd31, 5'd1, 5'd30, 1, 0, 1, 0, 0};

    // Reset state
    idle_in();
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_busy", {31'd0, MulDivBusy}, 0);
    chk("rst_done", {31'd0, MulDivDone}, 0);
    chk("rst_count", {16'd0, StallCount}, 0);
    chk("rst_pcwrite", {31'd0, PCWrite}, 1);
    @(negedge clk);
    rst = 0;

    // Vector table
    for (int i = 0; i < 10; i++) begin
      idle_in();
      MemReadIDEX = vt[i].mr; rtIDEX = vt[i].rte;
      rsIFID = vt[i].rs; rtIFID = vt[i].rt;
      UsesRtIFID = vt[i].ur; BranchTakenID = vt[i].br;
      cycle();
      chk($sformatf("vec%0d_pc", i), {31'd0, l_pc}, {31'd0, vt[i].e_pc});
      chk($sformatf("vec%0d_idexfl", i), {31'd0, l_idexfl},
          {31'd0, vt[i].e_idexfl});
      chk($sformatf("vec%0d_ifidfl", i), {31'd0, l_ifidfl},
          {31'd0, vt[i].e_ifidfl});
      if (i == 0) chk("lu_count_1", {16'd0, StallCount}, 1);
    end

    // MULT + MFHI: stall 0..4, done at 4, issue at 5
    idle_in(); StallCountClr = 1; cycle();
    for (int k = 0; k < 6; k++) begin
      idle_in();
      HiLoUseIFID = 1;
      MulDivStartIDEX = (k == 0);
      MulDivOpIDEX = 0;
      cycle();
      chk($sformatf("mult_done_c%0d", k), {31'd0, l_done},
          {31'd0, k == 4});
      chk($sformatf("mult_pc_c%0d", k), {31'd0, l_pc}, {31'd0, k == 5});
    end
    chk("mult_stall_count", {16'd0, StallCount}, 5);

    // DIV with a stray start at cycle 10
    for (int k = 0; k < 35; k++) begin
      idle_in();
      MulDivStartIDEX = (k == 0) || (k == 10);
      MulDivOpIDEX = 1;
      cycle();
      chk($sformatf("div_busy_c%0d", k), {31'd0, l_busy},
          {31'd0, k >= 1 && k <= 32});
      chk($sformatf("div_done_c%0d", k), {31'd0, l_done},
          {31'd0, k == 32});
    end

    // Reset in the middle of a MULT
    idle_in(); MulDivStartIDEX = 1; cycle();
    idle_in(); cycle();
    rst = 1;
    #1;
    chk("midrst_busy", {31'd0, MulDivBusy}, 0);
    chk("midrst_done", {31'd0, MulDivDone}, 0);
    chk("midrst_count", {16'd0, StallCount}, 0);
    m_left = 0; m_cnt = 0; m_sat = 0;
    @(negedge clk);
    rst = 0;
    for (int k = 0; k < 8; k++) begin
      idle_in(); cycle();
      chk($sformatf("midrst_nodone_c%0d", k), {31'd0, l_done}, 0);
    end

    // Saturation on the narrow counter, then clear beats stall
    for (int k = 0; k < 20; k++) begin
      idle_in(); MemReadIDEX = 1; rtIDEX = 4; rsIFID = 4; cycle();
    end
    chk("sat_allones", {28'd0, s_StallCount}, 32'hF);
    chk("wide_count_20", {16'd0, StallCount}, 20);
    idle_in(); MemReadIDEX = 1; rtIDEX = 4; rsIFID = 4;
    StallCountClr = 1; cycle();
    chk("clr_wins_wide", {16'd0, StallCount}, 0);
    chk("clr_wins_sat", {28'd0, s_StallCount}, 0);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      MemReadIDEX = 1'($urandom_range(0, 1));
      rtIDEX = 5'($urandom_range(0, 3));
      rsIFID = 5'($urandom_range(0, 3));
      rtIFID = 5'($urandom_range(0, 3));
      UsesRtIFID = 1'($urandom_range(0, 1));
      MulDivStartIDEX = ($urandom_range(0, 7) == 0);
      MulDivOpIDEX = ($urandom_range(0, 3) == 0);
      HiLoUseIFID = ($urandom_range(0, 3) == 0);
      BranchTakenID = 1'($urandom_range(0, 1));
      StallCountClr = ($urandom_range(0, 31) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline sequencing controller for the 5-stage core. Sits beside the forwarding logic in ID/EX and drives PC/IF-ID write enables and ID-EX/IF-ID flushes.
- Handles load-use stalls, ID-resolved branch flushes, and a multi-cycle MULT/DIV unit (HI/LO) through an internal FSM and cycle counter.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- MULT_CYCLES, 4, EX cycles a MULT occupies HI/LO (>=2).
- DIV_CYCLES, 32, EX cycles a DIV occupies HI/LO (>=2, <=64).
- CNT_W, 16, width of StallCount.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- MemReadIDEX  in  1  instruction in EX is a load
- rtIDEX  in  5  load destination register in EX
- rsIFID  in  5  rs of instruction in ID
- rtIFID  in  5  rt of instruction in ID
- UsesRtIFID  in  1  ID instruction reads rt as a source
- MulDivStartIDEX  in  1  EX instruction is MULT/DIV
- MulDivOpIDEX  in  1  0=MULT, 1=DIV
- HiLoUseIFID  in  1  ID instruction is MFHI/MFLO/MULT/DIV
- BranchTakenID  in  1  branch/jump in ID resolved taken
- StallCountClr  in  1  synchronous clear of StallCount
- PCWrite  out  1  PC update enable
- IFIDWrite  out  1  IF/ID register write enable
- IDEXFlush  out  1  insert bubble into ID/EX next edge
- IFIDFlush  out  1  zero IF/ID next edge (branch redirect)
- MulDivBusy  out  1  FSM not IDLE
- MulDivDone  out  1  one-cycle HI/LO write strobe
- StallCount  out  CNT_W  stall cycles since reset/clear

Behaviour:
- FSM states: IDLE, BUSY, DONE. Registers: state, 6-bit cnt, StallCount.
- Reset (async, any time, including mid-BUSY): state=IDLE, cnt=0, StallCount=0. MulDivBusy=0 and MulDivDone=0 immediately. An in-flight op is abandoned with no strobe.
- IDLE, MulDivStartIDEX=1: cnt <= (MulDivOpIDEX ? DIV_CYCLES : MULT_CYCLES) - 2, state <= BUSY.
- BUSY: if cnt==0, state <= DONE; else cnt <= cnt-1.
- DONE: MulDivDone=1 for exactly this cycle; state <= IDLE.
- Start-to-Done latency: MULT_CYCLES cycles after the start cycle. MULT=4 gives start at cycle 0, BUSY for cycles 1–3, DONE at cycle 4.
- MulDivStartIDEX while BUSY/DONE is a protocol violation. It is ignored: no restart, no counter change.
- MulDivBusy = (state != IDLE). Combinational, registered state only.
- loadUse = MemReadIDEX & (rtIDEX!=0) & ((rtIDEX==rsIFID) | (UsesRtIFID & rtIDEX==rtIFID)).
- hiloHaz = HiLoUseIFID & (MulDivStartIDEX | state!=IDLE). HI/LO readers stall through DONE inclusive and issue the cycle after DONE.
- stall = loadUse | hiloHaz.
- stall=1: PCWrite=0, IFIDWrite=0, IDEXFlush=1, IFIDFlush=0.
- stall=0: PCWrite=1, IFIDWrite=1, IDEXFlush=0, IFIDFlush=BranchTakenID.
- Stall has priority over a branch redirect. A taken branch held in ID by a stall does not flush; it redirects on the first non-stall cycle.
- All control outputs are combinational from inputs and state; no added latency.
- StallCount: StallCountClr has priority and sets it to 0. Otherwise it increments on each stall cycle and saturates at all-ones (no wrap). Clear and stall in the same cycle gives 0.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2), register-zero constant, MULT/DIV op encoding.
- One natural sub-module: muldiv_sequencer (FSM + cnt, outputs MulDivBusy/MulDivDone).
- Hazard equations and StallCount stay in the top level.

Test Plan:
- Load-use: MemReadIDEX=1, rtIDEX=8, rsIFID=8 -> PCWrite=0, IFIDWrite=0, IDEXFlush=1, StallCount 0->1. Repeat with rtIDEX=0 -> no stall.
- Rt gating: rtIDEX=9, rtIFID=9, rsIFID=3, UsesRtIFID=0 -> no stall; UsesRtIFID=1 -> stall.
- MULT + MFHI: start MULT at cycle 0, HiLoUseIFID=1 throughout -> stall cycles 0–4, MulDivDone=1 only at cycle 4, PCWrite=1 at cycle 5, StallCount=5.
- DIV timing and violation: DIV start, then pulse MulDivStartIDEX at cycle 10 -> ignored; MulDivDone exactly at cycle 32; MulDivBusy high cycles 1–32.
- Branch vs stall: BranchTakenID=1 with loadUse=1 -> IFIDFlush=0, PCWrite=0. Next cycle loadUse=0 -> IFIDFlush=1, PCWrite=1.
- Reset mid-op: assert rst during BUSY at cycle 2 of MULT -> MulDivBusy=0 immediately, no MulDivDone afterward. Also preload StallCount near all-ones and check it saturates at 16'hFFFF.
